// File: rtl/bus_client.sv
// bus_client: register-file bus slave with a programmable acknowledge delay.
// A request is captured in IDLE, optionally waits ACK_DELAY cycles in WAIT,
// and then completes in ACK, where the storage access and the ack happen on
// the same edge. Out-of-range addresses complete with err set and no write.
module bus_client #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int ACK_DELAY  = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  rq,
  input  logic                  wr_ni,
  input  logic [DATA_WIDTH-1:0] dataW,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] dataR,
  output logic                  err,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  // Counter preload: the WAIT state lasts ACK_DELAY edges, counting down to 0.
  localparam logic [7:0] WAIT_INIT = (ACK_DELAY > 0) ? 8'(ACK_DELAY - 1) : 8'd0;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                state_q, state_d;
  logic [7:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rd_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  capture;
  logic                  enter_ack;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic                  op_rd;
  logic [DATA_WIDTH-1:0] op_data;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] rd_word;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; enter_ack marks the edge that completes a transfer.
  always_comb begin
    state_d   = state_q;
    enter_ack = 1'b0;
    capture   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rq) begin
          capture = 1'b1;
          if (ACK_DELAY == 0) begin
            state_d   = S_ACK;
            enter_ack = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!rq) begin
          state_d = S_IDLE;
        end else if (wait_cnt == 8'd0) begin
          state_d   = S_ACK;
          enter_ack = 1'b1;
        end
      end
      S_ACK: begin
        if (!rq) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With no delay the transfer completes on the capture edge itself, so the
  // live inputs are used there; otherwise the captured copy is used.
  always_comb begin
    if (state_q == S_IDLE) begin
      op_addr = address;
      op_rd   = wr_ni;
      op_data = dataW;
    end else begin
      op_addr = addr_q;
      op_rd   = rd_q;
      op_data = data_q;
    end
    in_range = {1'b0, op_addr} < DEPTH_L;
  end

  // Read mux over the storage words.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, op_addr} == i[ADDR_WIDTH:0]) rd_word = mem[i];
    end
  end

  // Request capture and wait countdown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      rd_q     <= 1'b0;
      data_q   <= '0;
      wait_cnt <= 8'd0;
    end else begin
      if (capture) begin
        addr_q   <= address;
        rd_q     <= wr_ni;
        data_q   <= dataW;
        wait_cnt <= WAIT_INIT;
      end else if (state_q == S_WAIT && rq && wait_cnt != 8'd0) begin
        wait_cnt <= wait_cnt - 8'd1;
      end
    end
  end

  // Storage words; written only on the edge that enters ACK.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enter_ack && !op_rd && in_range) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ({1'b0, op_addr} == i[ADDR_WIDTH:0]) mem[i] <= op_data;
      end
    end
  end

  // Registered response: ack/err/dataR and the completed-transfer counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack      <= 1'b0;
      err      <= 1'b0;
      dataR    <= '0;
      xfer_cnt <= '0;
    end else if (enter_ack) begin
      ack      <= 1'b1;
      err      <= !in_range;
      xfer_cnt <= xfer_cnt + 1'b1;
      if (op_rd) dataR <= in_range ? rd_word : '0;
    end else if (state_q == S_ACK && !rq) begin
      ack <= 1'b0;
      err <= 1'b0;
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_client.sv
// tb_bus_client: two bus_client instances (no delay / delay 3 with a short
// storage and a 2-bit counter) driven by directed and random transfers and
// compared against a transaction-level model of storage, dataR and counter.
module tb_bus_client;

  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] address;
  logic          wr_ni;
  logic [DW-1:0] dataW;
  logic          rq0, rq1;
  logic          ack0, ack1, err0, err1, busy0, busy1;
  logic [DW-1:0] dr0, dr1;
  logic [15:0]   cnt0;
  logic [1:0]    cnt1;

  bus_client #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(16), .ACK_DELAY(0), .CNT_WIDTH(16)) u0 (
    .clk(clk), .reset(reset), .address(address), .rq(rq0), .wr_ni(wr_ni), .dataW(dataW),
    .ack(ack0), .dataR(dr0), .err(err0), .busy(busy0), .xfer_cnt(cnt0));

  bus_client #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(12), .ACK_DELAY(3), .CNT_WIDTH(2)) u1 (
    .clk(clk), .reset(reset), .address(address), .rq(rq1), .wr_ni(wr_ni), .dataW(dataW),
    .ack(ack1), .dataR(dr1), .err(err1), .busy(busy1), .xfer_cnt(cnt1));

  int total = 0;
  int bad   = 0;

  // Reference model, one entry per instance.
  int            dly [2] = '{0, 3};
  int            dep [2] = '{16, 12};
  int            cmod[2] = '{65536, 4};
  logic [DW-1:0] mem_m[2][16];
  logic [DW-1:0] dr_m [2];
  int            cnt_m[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] o_ack(input int s);  return s ? 32'(ack1)  : 32'(ack0);  endfunction
  function automatic logic [31:0] o_err(input int s);  return s ? 32'(err1)  : 32'(err0);  endfunction
  function automatic logic [31:0] o_busy(input int s); return s ? 32'(busy1) : 32'(busy0); endfunction
  function automatic logic [31:0] o_dr(input int s);   return s ? 32'(dr1)   : 32'(dr0);   endfunction
  function automatic logic [31:0] o_cnt(input int s);  return s ? 32'(cnt1)  : 32'(cnt0);  endfunction

  task automatic set_rq(input int s, input logic v);
    if (s != 0) rq1 = v;
    else        rq0 = v;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) mem_m[s][a] = '0;
      dr_m[s]  = '0;
      cnt_m[s] = 0;
    end
  endtask

  // One transfer on instance s; abort_at >= 0 drops rq after that many wait edges.
  task automatic xfer(input int s, input logic [AW-1:0] a, input logic rd,
                      input logic [DW-1:0] d, input int abort_at);
    @(negedge clk);
    address = a; wr_ni = rd; dataW = d;
    set_rq(s, 1'b1);
    @(posedge clk); #1;
    // Scramble the inputs: the captured request must be unaffected.
    address = AW'($urandom); wr_ni = 1'($urandom); dataW = DW'($urandom);
    for (int j = 0; j < dly[s]; j++) begin
      chk("wait_ack", o_ack(s), 0);
      chk("wait_busy", o_busy(s), 1);
      if (abort_at == j) begin
        @(negedge clk);
        set_rq(s, 1'b0);
        @(posedge clk); #1;
        chk("abort_busy", o_busy(s), 0);
        chk("abort_ack", o_ack(s), 0);
        chk("abort_cnt", o_cnt(s), 32'(cnt_m[s]));
        return;
      end
      @(posedge clk); #1;
    end
    if (rd) dr_m[s] = (int'(a) < dep[s]) ? mem_m[s][a] : '0;
    else if (int'(a) < dep[s]) mem_m[s][a] = d;
    cnt_m[s] = (cnt_m[s] + 1) % cmod[s];
    chk("ack", o_ack(s), 1);
    chk("err", o_err(s), (int'(a) >= dep[s]) ? 1 : 0);
    chk("dataR", o_dr(s), 32'(dr_m[s]));
    chk("cnt", o_cnt(s), 32'(cnt_m[s]));
    chk("ack_busy", o_busy(s), 1);
    @(posedge clk); #1;
    chk("hold_ack", o_ack(s), 1);
    chk("hold_dataR", o_dr(s), 32'(dr_m[s]));
    @(negedge clk);
    set_rq(s, 1'b0);
    @(posedge clk); #1;
    chk("rel_ack", o_ack(s), 0);
    chk("rel_err", o_err(s), 0);
    chk("rel_busy", o_busy(s), 0);
    chk("rel_dataR", o_dr(s), 32'(dr_m[s]));
  endtask

  initial begin
    reset = 1'b0; rq0 = 1'b0; rq1 = 1'b0;
    address = '0; wr_ni = 1'b0; dataW = '0;
    model_reset();
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_ack", o_ack(s), 0);
      chk("rst_err", o_err(s), 0);
      chk("rst_dataR", o_dr(s), 0);
      chk("rst_cnt", o_cnt(s), 0);
      chk("rst_busy", o_busy(s), 0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Write then read back with no delay.
    xfer(0, 4'd3, 1'b0, 8'hA5, -1);
    xfer(0, 4'd3, 1'b1, 8'h00, -1);
    chk("wr_rd_cnt", 32'(cnt0), 2);

    // Delayed read of a reset word.
    xfer(1, 4'd0, 1'b1, 8'h00, -1);

    // Out-of-range write and read on the short storage.
    xfer(1, 4'd13, 1'b0, 8'h3C, -1);
    xfer(1, 4'd13, 1'b1, 8'h00, -1);
    for (int a = 0; a < 12; a++) xfer(1, AW'(a), 1'b1, 8'h00, -1);

    // Aborted write after one wait cycle, then read the word back.
    xfer(1, 4'd5, 1'b0, 8'h77, 1);
    xfer(1, 4'd5, 1'b1, 8'h00, -1);

    // Reset while in ACK after a write.
    @(negedge clk);
    address = 4'd2; wr_ni = 1'b0; dataW = 8'hFF; rq0 = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_ack", 32'(ack0), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(ack0), 0);
    chk("mid_rst_err", 32'(err0), 0);
    chk("mid_rst_dataR", 32'(dr0), 0);
    chk("mid_rst_cnt", 32'(cnt0), 0);
    rq0 = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    xfer(0, 4'd2, 1'b1, 8'h00, -1);

    // Counter wrap on a 2-bit counter: 1,2,3,0,1.
    for (int i = 0; i < 5; i++) xfer(1, AW'($urandom_range(0, 11)), 1'($urandom), DW'($urandom), -1);

    // Random traffic on both instances.
    for (int i = 0; i < 40; i++) begin
      xfer(0, AW'($urandom), 1'($urandom), DW'($urandom), -1);
      xfer(1, AW'($urandom), 1'($urandom), DW'($urandom),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1);
    end

    // Final sweep of every address on both instances.
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++) xfer(s, AW'(a), 1'b1, 8'h00, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_client.md
BUS_CLIENT -- requirements
Module: bus_client

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bus width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, address bus width in bits.
REQ-003 Parameter DEPTH, default 16, number of storage words, 1..2^ADDR_WIDTH.
REQ-004 Parameter ACK_DELAY, default 0, number of wait cycles inserted before ack (0..255).
REQ-005 Parameter CNT_WIDTH, default 16, width of the completed-transfer counter.
REQ-006 Port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-007 Port reset, input, 1, asynchronous reset, active-low (0 = reset).
REQ-008 Port address, input, ADDR_WIDTH, word address of the request.
REQ-009 Port rq, input, 1, request from the arbiter, level-held until ack is seen.
REQ-010 Port wr_ni, input, 1, operation select: 1 = read, 0 = write.
REQ-011 Port dataW, input, DATA_WIDTH, write data.
REQ-012 Port ack, output, 1, registered acknowledge.
REQ-013 Port dataR, output, DATA_WIDTH, registered read data.
REQ-014 Port err, output, 1, registered out-of-range flag, valid while ack=1.
REQ-015 Port busy, output, 1, high in every state except IDLE.
REQ-016 Port xfer_cnt, output, CNT_WIDTH, count of completed (acknowledged) transfers.

Function
REQ-017 The block SHALL contain DEPTH registers of DATA_WIDTH bits as its storage.
REQ-018 The FSM SHALL have states IDLE, WAIT, ACK; the encoding is free.
REQ-019 IDLE, rq=1 at an edge: capture address, wr_ni, dataW; go to WAIT with the wait counter loaded to ACK_DELAY-1 if ACK_DELAY>0, else go directly to ACK.
REQ-020 WAIT: while rq=1, decrement the counter each edge; at counter=0, go to ACK.
REQ-021 WAIT with rq=0 at an edge (abort): go to IDLE; no storage write, no ack, xfer_cnt unchanged.
REQ-022 Entering ACK: ack<=1 on the same edge; rq first sampled high at edge k yields ack=1 after edge k+ACK_DELAY.
REQ-023 On entering ACK, a read with captured address < DEPTH SHALL load dataR with storage[address].
REQ-024 On entering ACK, a write with captured address < DEPTH SHALL update storage[address] with the captured dataW; dataR holds its value.
REQ-025 Captured address >= DEPTH: no storage write; a read loads dataR with 0; err<=1 on the ack edge.
REQ-026 ACK: ack, err and dataR SHALL hold while rq=1.
REQ-027 ACK, rq=0 at an edge: ack<=0, err<=0, go to IDLE; dataR holds its last value.
REQ-028 xfer_cnt SHALL increment by 1 on each edge that enters ACK, including err transfers, and wrap modulo 2^CNT_WIDTH.
REQ-029 Inputs address, wr_ni and dataW changing after capture SHALL NOT affect the current transfer.
REQ-030 A new request SHALL only be accepted in IDLE, so rq must be low for at least one edge between transfers.
REQ-031 ACK_DELAY=0 and ACK_DELAY=255 SHALL both be supported with no other behavioural change.

Reset
REQ-032 reset=0 SHALL immediately, independent of clk, force: state IDLE, ack=0, err=0, dataR=0, xfer_cnt=0, wait counter=0, all storage words=0.
REQ-033 Reset asserted mid-transfer (WAIT or ACK) SHALL abandon the transfer with no storage write; operation resumes at the first edge after reset=1.

Verification
REQ-034 ACK_DELAY=0: write addr 3, dataW 0xA5, then read addr 3 -> ack rises one edge after rq sampled, read dataR=0xA5, err=0, xfer_cnt=2.
REQ-035 ACK_DELAY=3: read addr 0 after reset -> ack rises at the 4th edge after rq sampled, busy=1 for the WAIT cycles, dataR=0x00.
REQ-036 DEPTH=12: write 0x3C to addr 13, then read addr 13 -> both acked with err=1; read dataR=0x00; storage words 0..11 unchanged.
REQ-037 ACK_DELAY=3: rq dropped after 1 wait cycle on a write to addr 5 -> no ack, busy=0 next edge, storage[5] unchanged, xfer_cnt unchanged.
REQ-038 Reset pulsed low while in ACK after a write of 0xFF to addr 2 -> ack, err, dataR and xfer_cnt read 0 immediately; a later read of addr 2 returns 0x00.
REQ-039 CNT_WIDTH=2: 5 back-to-back transfers -> xfer_cnt sequence 1,2,3,0,1.
